mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Single-port wait-state memory responder: IDLE/WAIT/RESP handshake over a
// 2**ADDR_W x DATA_W array with saturating read/write completion counters.
module mem_responder #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              busy,
    output logic              err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  LAST_CNT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_wr;

    logic              accept;
    logic              illegal;
    logic              enter_resp;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_wr;

    logic [DATA_W-1:0] mem [DEPTH];

    // With no wait states the access happens on the accepting edge, so the
    // live request fields feed the array instead of the latched copies.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        illegal      = 1'b0;
        enter_resp   = 1'b0;
        acc_addr     = lat_addr;
        acc_data     = lat_data;
        acc_wr       = lat_wr;
        case (state)
            IDLE: begin
                if (read ^ write) begin
                    accept       = 1'b1;
                    acc_addr     = addr;
                    acc_data     = data_in;
                    acc_wr       = write;
                    wait_cnt_nxt = '0;
                    if (WAIT_CYC == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else if (read && write) begin
                    illegal = 1'b1;
                end
            end
            WAIT: begin
                if (wait_cnt == LAST_CNT) begin
                    state_nxt    = RESP;
                    enter_resp   = 1'b1;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                lat_addr <= addr;
                lat_data <= data_in;
                lat_wr   <= write;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            data_out <= '0;
            rd_count <= '0;
            wr_count <= '0;
            err      <= 1'b0;
        end else begin
            err <= illegal;
            if (enter_resp) begin
                if (acc_wr) begin
                    mem[acc_addr] <= acc_data;
                    if (wr_count != '1) wr_count <= wr_count + 16'd1;
                end else begin
                    data_out <= mem[acc_addr];
                    if (rd_count != '1) rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);

endmodule
